pwm_bank: RTL and testbench
===========================

# pwm_bank

Parametrised multi-channel PWM generator. CHANNELS outputs share one period counter. Each channel has its own duty register, and one period register is shared by all channels. Duty and period writes are double-buffered and take effect only at a cycle boundary. The block supports edge-aligned and center-aligned counting, per-channel enable and polarity, and an external resync. It sits between the register/bus interface and the output pins, and replaces the single-channel generator in multi-output designs.

## Interface
- CHANNELS, 4: number of PWM outputs (1..16).
- WIDTH, 16: counter, duty and period width in bits.
- AW, $clog2(CHANNELS+1): write-address width.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- wr_en  in  1  write strobe, one write per cycle.
- wr_addr  in  AW  0..CHANNELS-1 selects the duty shadow of channel i; CHANNELS selects the period shadow; larger values are ignored.
- wr_data  in  WIDTH  value to write.
- cfg_center  in  1  mode: 0 = edge-aligned, 1 = center-aligned. Sampled only at a boundary.
- sync  in  1  forces an immediate boundary (restarts the cycle).
- ch_enable  in  CHANNELS  per-channel enable; sampled every cycle.
- ch_invert  in  CHANNELS  per-channel polarity; sampled every cycle.
- pwm_out  out  CHANNELS  registered PWM outputs.
- cycle_start  out  1  registered one-cycle pulse marking the first output cycle of each PWM cycle.

## Operation
- State:
  - cnt (WIDTH) and dir (up/down).
  - Shadow registers: duty_sh[i] and per_sh.
  - Active registers: duty_act[i], per_act, mode_act.
- Writes always go to the shadow registers.
- Boundary condition (bnd), evaluated each cycle from current state:
  - per_act == 0, or
  - edge mode and cnt == per_act-1, or
  - center mode and dir == down and cnt == 0.
- On bnd or sync:
  - Next cnt = 0 and dir = up.
  - duty_act, per_act and mode_act load from the shadows and cfg_center.
  - A write in the same cycle is forwarded: the written value is loaded, not the stale shadow.
- Edge mode: cnt counts 0,1,…,per_act-1 and wraps. One PWM cycle is per_act clocks.
- Center mode: cnt runs 0,1,…,P-1,P-1,…,1,0, where P = per_act.
  - dir flips to down on the cycle after cnt reaches P-1 going up; P-1 is held for 2 cycles.
  - One PWM cycle is 2P clocks.
- Raw level: raw[i] = (per_act != 0) && (cnt < duty_act[i]), unsigned WIDTH-bit compare.
- Registered output: pwm_out[i] <= (ch_enable[i] & raw[i]) ^ ch_invert[i].
  - A disabled channel drives ch_invert[i].
- Duty boundary cases:
  - duty 0 gives a constant inactive level.
  - duty >= per_act gives a constant active level (100 %).
  - In center mode the active time is 2*min(duty, P) clocks per cycle.
- Stopped state: per_act == 0.
  - cnt is held at 0 and bnd is true every cycle, so the shadows load each cycle.
  - Every output is held at ch_invert[i].
  - cycle_start stays 0 while stopped.
- Priority: reset > sync > bnd > count.

## Timing
- Reset values:
  - cnt = 0, dir = up.
  - All shadow and active registers = 0; mode_act = edge.
  - pwm_out = 0 and cycle_start = 0, regardless of ch_invert.
  - From the first clock after reset, outputs follow ch_invert.
- Output latency: pwm_out reflects cnt/duty_act from the previous cycle, i.e. one clock of latency.
- cycle_start is high in the cycle where pwm_out first reflects cnt == 0 of a new cycle. That is 2 clocks after the bnd/sync cycle in which the load was decided.
- A shadow write in cycle t reaches pwm_out no earlier than the first cycle_start after the next bnd/sync at or after t.
- Registers written by ch_enable/ch_invert changes appear on pwm_out after 1 clock.
- sync in the middle of a cycle truncates the current cycle. The new cycle's cnt = 0 occurs in the next clock.
- Reset in the middle of a cycle overrides everything in the same clock edge, including a pending write.
- Period change from N to M:
  - The current cycle completes with N clocks.
  - The next cycle has M clocks, with no partial or glitch cycle.

## Test plan
- Edge mode, per = 10, duty0 = 3, ch0 enabled, non-inverted → ch0 is high 3 clocks and low 7; cycle_start pulses every 10 clocks, aligned with the rising edge of ch0.
- Shadow buffering: write duty0 = 7 at count 4 of a duty-3 cycle → the current pulse stays 3 clocks; the next cycle is 7 high / 3 low; a write at the bnd cycle itself takes effect in the immediately following cycle.
- Duty boundary cases, per = 8: duty = 0 → constant 0; duty = 8 and duty = 12 → constant 1; per = 0 → all outputs equal ch_invert and cycle_start never pulses.
- Center mode, per = 4, duty = 1 → cnt sequence is 0,1,2,3,3,2,1,0; the output is high for 2 clocks straddling the wrap in an 8-clock period; duty = 4 → constant high.
- Enable and invert: ch1 inverted with duty 2 of 5 → ch1 is low 2 / high 3; ch2 disabled and inverted → constant 1; toggling ch_enable changes pwm_out after 1 clock.
- sync asserted at count 6 of per = 10 → the cycle restarts; cycle_start appears 2 clocks later. Reset asserted mid-pulse → the next clock gives pwm_out = 0 and cycle_start = 0, and all registers read back to 0.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with one shared period counter and double-buffered
// duty/period registers that switch over only at a PWM cycle boundary.

module pwm_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             load,
  input  logic [WIDTH-1:0] cnt,
  input  logic             run,
  input  logic             enable,
  input  logic             invert,
  output logic             pwm
);
  logic [WIDTH-1:0] duty_sh, duty_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wr_sel) duty_sh <= wr_data;
      // a write landing on the load cycle is forwarded past the stale shadow
      if (load) duty_act <= wr_sel ? wr_data : duty_sh;
      pwm <= (enable & run & (cnt < duty_act)) ^ invert;
    end
  end
endmodule

module pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int AW       = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                cfg_center,
  input  logic                sync,
  input  logic [CHANNELS-1:0] ch_enable,
  input  logic [CHANNELS-1:0] ch_invert,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                cycle_start
);
  localparam logic [AW-1:0]    PER_ADDR = AW'(CHANNELS);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] cnt, per_sh, per_act;
  logic             down, mode_act, run, bnd, load, per_wr;
  logic [1:0]       vld_pipe;

  assign run    = (per_act != '0);
  assign per_wr = wr_en && (wr_addr == PER_ADDR);
  assign bnd    = !run
               || (!mode_act && (cnt == per_act - ONE))
               || ( mode_act && down && (cnt == '0));
  assign load   = bnd || sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      down     <= 1'b0;
      per_sh   <= '0;
      per_act  <= '0;
      mode_act <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (per_wr) per_sh <= wr_data;
      // stage 0: load decided; stage 1: cnt==0 visible on pwm_out, suppressed when stopped
      vld_pipe <= {vld_pipe[0] & run, load};
      if (load) begin
        cnt      <= '0;
        down     <= 1'b0;
        per_act  <= per_wr ? wr_data : per_sh;
        mode_act <= cfg_center;
      end else if (!mode_act) begin
        cnt <= cnt + ONE;
      end else if (!down) begin
        // the top count is held one extra clock while turning around
        if (cnt == per_act - ONE) down <= 1'b1;
        else                      cnt  <= cnt + ONE;
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

  assign cycle_start = vld_pipe[1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_sel  (wr_en && (wr_addr == AW'(i))),
      .wr_data (wr_data),
      .load    (load),
      .cnt     (cnt),
      .run     (run),
      .enable  (ch_enable[i]),
      .invert  (ch_invert[i]),
      .pwm     (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: a cycle model pushes expected outputs per clock,
// popped and compared after each edge, plus directed duty/period measurements.

module tb_pwm_bank;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          cfg_center = 1'b0;
  logic          sync = 1'b0;
  logic [CH-1:0] ch_enable = '0;
  logic [CH-1:0] ch_invert = '0;
  logic [CH-1:0] pwm_out;
  logic          cycle_start;

  pwm_bank #(.CHANNELS(CH), .WIDTH(W), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cfg_center  (cfg_center),
    .sync        (sync),
    .ch_enable   (ch_enable),
    .ch_invert   (ch_invert),
    .pwm_out     (pwm_out),
    .cycle_start (cycle_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] m_cnt = '0, m_psh = '0, m_pact = '0;
  logic [W-1:0] m_dsh[CH];
  logic [W-1:0] m_dact[CH];
  logic         m_down = 1'b0, m_mode = 1'b0, m_loadq = 1'b0;
  logic [CH:0]  exp_q[$];
  int           hi[CH];
  int           cs_n;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour for the edge that ends the current cycle.
  task automatic model_step();
    logic          bnd, ld, cs;
    logic [CH-1:0] p;
    if (reset) begin
      m_cnt = '0; m_down = 1'b0; m_psh = '0; m_pact = '0; m_mode = 1'b0; m_loadq = 1'b0;
      for (int i = 0; i < CH; i++) begin m_dsh[i] = '0; m_dact[i] = '0; end
      exp_q.push_back('0);
      return;
    end
    for (int i = 0; i < CH; i++)
      p[i] = (ch_enable[i] && (m_pact != 0) && (m_cnt < m_dact[i])) ^ ch_invert[i];
    cs  = m_loadq && (m_pact != 0);
    bnd = (m_pact == 0) || (!m_mode && m_cnt == m_pact - 16'd1) || (m_mode && m_down && m_cnt == 0);
    ld  = bnd || sync;
    if (wr_en) begin
      if (wr_addr < CH)       m_dsh[wr_addr[1:0]] = wr_data;
      else if (wr_addr == CH) m_psh = wr_data;
    end
    if (ld) begin
      for (int i = 0; i < CH; i++) m_dact[i] = m_dsh[i];
      m_pact = m_psh; m_mode = cfg_center; m_cnt = '0; m_down = 1'b0;
    end else if (!m_mode) begin
      m_cnt = m_cnt + 16'd1;
    end else if (!m_down) begin
      if (m_cnt == m_pact - 16'd1) m_down = 1'b1;
      else m_cnt = m_cnt + 16'd1;
    end else begin
      m_cnt = m_cnt - 16'd1;
    end
    m_loadq = ld;
    exp_q.push_back({p, cs});
  endtask

  task automatic step();
    logic [CH:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pwm_out", 32'(pwm_out), 32'(e[CH:1]));
    chk("cycle_start", 32'(cycle_start), 32'(e[0]));
    for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
    cs_n += int'(cycle_start);
  endtask

  task automatic window(input int n);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    cs_n = 0;
    repeat (n) step();
  endtask

  task automatic wait_cs();
    int k = 0;
    do begin step(); k++; end while (!cycle_start && k < 100);
    chk("wait_cs_timeout", 32'(cycle_start), 32'd1);
  endtask

  task automatic write(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(d);
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    cs_n = 0;

    // reset state ignores ch_invert
    ch_invert = 4'b0101;
    repeat (3) step();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_cs", 32'(cycle_start), 32'd0);

    // edge mode, per 10 duty 3
    reset = 1'b0; ch_invert = '0; ch_enable = 4'b0001;
    write(0, 3); write(4, 10);
    wait_cs();
    chk("edge_align", 32'(pwm_out[0]), 32'd1);
    window(10);
    chk("edge_hi", hi[0], 3);
    chk("edge_cs", cs_n, 1);

    // shadow write mid-cycle leaves the current pulse untouched
    repeat (3) step();
    write(0, 7);
    window(0);
    wait_cs();
    chk("shadow_hold", hi[0], 1);
    window(10);
    chk("shadow_new_hi", hi[0], 7);

    // write in the boundary cycle applies to the very next cycle
    repeat (8) step();
    write(0, 2);
    step();
    chk("bnd_wr_cs", 32'(cycle_start), 32'd1);
    window(10);
    chk("bnd_wr_hi", hi[0], 2);

    // duty boundary cases, per 8
    ch_enable = 4'b0111;
    write(1, 8); write(2, 12); write(0, 0); write(4, 8);
    wait_cs(); wait_cs();
    window(8);
    chk("duty0_hi", hi[0], 0);
    chk("duty8_hi", hi[1], 8);
    chk("duty12_hi", hi[2], 8);
    chk("per8_cs", cs_n, 1);

    // stopped: per 0
    write(4, 0);
    repeat (12) step();
    ch_invert = 4'b1010;
    window(20);
    chk("stop_cs", cs_n, 0);
    chk("stop_hi0", hi[0], 0);
    chk("stop_hi1", hi[1], 20);
    chk("stop_out", 32'(pwm_out), 32'hA);

    // center mode, per 4 duty 1
    ch_invert = '0; ch_enable = 4'b0001; cfg_center = 1'b1;
    write(0, 1); write(4, 4);
    wait_cs();
    pat = '0;
    for (int j = 0; j < 8; j++) begin step(); pat[j] = pwm_out[0]; end
    chk("ctr_pat", 32'(pat), 32'hC0);
    write(0, 4);
    wait_cs(); wait_cs();
    window(8);
    chk("ctr_full_hi", hi[0], 8);
    chk("ctr_cs", cs_n, 1);

    // enable and invert, per 5
    cfg_center = 1'b0;
    write(1, 2); write(2, 2); write(4, 5);
    ch_enable = 4'b0011; ch_invert = 4'b0110;
    wait_cs(); wait_cs();
    window(5);
    chk("inv_hi1", hi[1], 3);
    chk("dis_inv_hi2", hi[2], 5);
    ch_enable[1] = 1'b0;
    step();
    chk("en_off", 32'(pwm_out[1]), 32'd1);
    ch_enable[1] = 1'b1;
    repeat (3) step();

    // sync at count 6 of per 10
    ch_invert = '0;
    write(4, 10); write(0, 3);
    wait_cs(); wait_cs();
    repeat (5) step();
    sync = 1'b1; step(); sync = 1'b0;
    step();
    chk("sync_cs", 32'(cycle_start), 32'd1);
    window(10);
    chk("sync_hi", hi[0], 3);

    // reset mid-pulse drops a simultaneous write and clears all registers
    wait_cs();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd10;
    step();
    chk("rst_mid_pwm", 32'(pwm_out), 32'd0);
    chk("rst_mid_cs", 32'(cycle_start), 32'd0);
    reset = 1'b0; wr_en = 1'b0;
    ch_enable = 4'hF; ch_invert = 4'b0101;
    window(20);
    chk("post_rst_cs", cs_n, 0);
    chk("post_rst_hi0", hi[0], 20);
    chk("post_rst_hi1", hi[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
